plca_txop_table_writer: RTL and testbench

- Write side of the PLCA TXOP occupancy table; the hard-claim query, max-hard-claim check and free-TXOP pick functions are its readers.
- Observes per-TXOP activity reported by the PLCA control path and records occupancy and hard-claim status per node ID.
- Ages entries once per PLCA cycle and publishes the free count, hard-claim count, lowest free TXOP and the max-hard-claim flag.
- Sits beside the PLCA control state diagram, which drives it.

---
 rtl/plca_txop_table_writer.sv | 261 ++++++++++++++++++++++++++
 tb/tb_plca_txop_table_writer.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plca_txop_table_writer.sv
// PLCA TXOP occupancy table, write side: clear, per-cycle sweep, summaries.
// Optional aging of idle entries is enabled by defining TXOP_AGING_EN.
module plca_txop_table_writer #(
  parameter int DEPTH           = 256,
  parameter int AGE_W           = 4,
  parameter int AGE_LIMIT       = 8,
  parameter int MAX_HARD_CLAIMS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear_req,
  input  logic       cycle_start,
  input  logic       txop_valid,
  input  logic [7:0] txop_id,
  input  logic       txop_active,
  input  logic       txop_hard,
  input  logic [7:0] rd_id,
  output logic       rd_occ,
  output logic       rd_hard,
  output logic       busy,
  output logic       clear_done,
  output logic       sweep_done,
  output logic [8:0] free_count,
  output logic [8:0] hard_count,
  output logic [7:0] first_free,
  output logic       free_valid,
  output logic       max_hard_claim,
  output logic       sweep_overrun
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_SWEEP} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [8:0]    free_acc_q, free_acc_d;
  logic [8:0]    hard_acc_q, hard_acc_d;
  logic [7:0]    ff_acc_q, ff_acc_d;
  logic          ff_found_q, ff_found_d;
  logic [8:0]    free_count_q, free_count_d;
  logic [8:0]    hard_count_q, hard_count_d;
  logic [7:0]    first_free_q, first_free_d;
  logic          free_valid_q, free_valid_d;
  logic          max_hard_q, max_hard_d;
  logic          clear_done_q, clear_done_d;
  logic          sweep_done_q, sweep_done_d;
  logic          overrun_q, overrun_d;
  logic          rd_occ_q, rd_occ_d;
  logic          rd_hard_q, rd_hard_d;

  logic occ_q  [DEPTH];
  logic hard_q [DEPTH];
`ifdef TXOP_AGING_EN
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [AGE_W-1:0] cur_age, age_inc, swp_age, tw_age;
  logic             expire;
`endif

  logic          cur_occ, cur_hard, swp_occ, swp_hard;
  logic          ev_ok, ev_hit, cnt_occ, cnt_hard, cnt_free, cnt_hd;
  logic [IW-1:0] ev_idx;
  logic [8:0]    free_nx, hard_nx;
  logic [7:0]    ff_nx;
  logic          found_nx;
  logic          tw_en, tw_occ, tw_hard;

  always_comb begin
    cur_occ  = occ_q[idx_q];
    cur_hard = hard_q[idx_q];
`ifdef TXOP_AGING_EN
    cur_age  = age_q[idx_q];
    age_inc  = (cur_age == '1) ? cur_age : cur_age + 1'b1;
    expire   = cur_occ && (age_inc == AGE_W'(AGE_LIMIT));
    swp_occ  = cur_occ && !expire;
    swp_hard = cur_hard && !expire;
    swp_age  = cur_occ ? age_inc : cur_age;
`else
    swp_occ  = cur_occ;
    swp_hard = cur_hard;
`endif
    ev_ok    = txop_valid && txop_active && (state_q != S_CLEAR) &&
               ({1'b0, txop_id} < 9'(DEPTH));
    ev_idx   = txop_id[IW-1:0];
    ev_hit   = ev_ok && (ev_idx == idx_q);
    // a same-entry event overrides the aged view of the entry
    cnt_occ  = ev_hit || swp_occ;
    cnt_hard = ev_hit ? txop_hard : swp_hard;
    cnt_free = (idx_q != '0) && !cnt_occ;
    cnt_hd   = (idx_q != '0) && cnt_hard;
    free_nx  = free_acc_q + 9'(cnt_free);
    hard_nx  = hard_acc_q + 9'(cnt_hd);
    ff_nx    = ff_acc_q;
    found_nx = ff_found_q;
    if (cnt_free && !ff_found_q) begin
      ff_nx    = 8'(idx_q);
      found_nx = 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    free_acc_d   = free_acc_q;
    hard_acc_d   = hard_acc_q;
    ff_acc_d     = ff_acc_q;
    ff_found_d   = ff_found_q;
    free_count_d = free_count_q;
    hard_count_d = hard_count_q;
    first_free_d = first_free_q;
    free_valid_d = free_valid_q;
    max_hard_d   = max_hard_q;
    clear_done_d = 1'b0;
    sweep_done_d = 1'b0;
    overrun_d    = overrun_q;
    tw_en        = 1'b0;
    tw_occ       = 1'b0;
    tw_hard      = 1'b0;
`ifdef TXOP_AGING_EN
    tw_age       = '0;
`endif
    rd_occ_d     = 1'b0;
    rd_hard_d    = 1'b0;
    if ({1'b0, rd_id} < 9'(DEPTH)) begin
      rd_occ_d  = occ_q[rd_id[IW-1:0]];
      rd_hard_d = hard_q[rd_id[IW-1:0]];
    end
    unique case (state_q)
      S_CLEAR: begin
        tw_en = 1'b1;
        if (cycle_start) overrun_d = 1'b1;
        if (idx_q == LAST) begin
          state_d      = S_IDLE;
          idx_d        = '0;
          clear_done_d = 1'b1;
          free_count_d = 9'(DEPTH - 1);
          hard_count_d = '0;
          first_free_d = (DEPTH > 1) ? 8'd1 : 8'd0;
          free_valid_d = (DEPTH > 1);
          max_hard_d   = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (cycle_start) begin
          state_d    = S_SWEEP;
          idx_d      = '0;
          free_acc_d = '0;
          hard_acc_d = '0;
          ff_acc_d   = '0;
          ff_found_d = 1'b0;
        end
      end
      S_SWEEP: begin
        if (cycle_start) overrun_d = 1'b1;
        if (clear_req) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else begin
`ifdef TXOP_AGING_EN
          tw_en   = 1'b1;
          tw_occ  = swp_occ;
          tw_hard = swp_hard;
          tw_age  = swp_age;
`endif
          free_acc_d = free_nx;
          hard_acc_d = hard_nx;
          ff_acc_d   = ff_nx;
          ff_found_d = found_nx;
          if (idx_q == LAST) begin
            state_d      = S_IDLE;
            idx_d        = '0;
            sweep_done_d = 1'b1;
            free_count_d = free_nx;
            hard_count_d = hard_nx;
            first_free_d = found_nx ? ff_nx : 8'd0;
            free_valid_d = found_nx;
            max_hard_d   = (hard_nx >= 9'(MAX_HARD_CLAIMS));
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLEAR;
      idx_q        <= '0;
      free_acc_q   <= '0;
      hard_acc_q   <= '0;
      ff_acc_q     <= '0;
      ff_found_q   <= 1'b0;
      free_count_q <= '0;
      hard_count_q <= '0;
      first_free_q <= '0;
      free_valid_q <= 1'b0;
      max_hard_q   <= 1'b0;
      clear_done_q <= 1'b0;
      sweep_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      rd_occ_q     <= 1'b0;
      rd_hard_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      free_acc_q   <= free_acc_d;
      hard_acc_q   <= hard_acc_d;
      ff_acc_q     <= ff_acc_d;
      ff_found_q   <= ff_found_d;
      free_count_q <= free_count_d;
      hard_count_q <= hard_count_d;
      first_free_q <= first_free_d;
      free_valid_q <= free_valid_d;
      max_hard_q   <= max_hard_d;
      clear_done_q <= clear_done_d;
      sweep_done_q <= sweep_done_d;
      overrun_q    <= overrun_d;
      rd_occ_q     <= rd_occ_d;
      rd_hard_q    <= rd_hard_d;
    end
  end

  // table is initialised by the CLEAR walk, so it carries no reset
  always_ff @(posedge clk) begin
    if (tw_en) begin
      occ_q[idx_q]  <= tw_occ;
      hard_q[idx_q] <= tw_hard;
`ifdef TXOP_AGING_EN
      age_q[idx_q]  <= tw_age;
`endif
    end
    if (ev_ok) begin
      occ_q[ev_idx]  <= 1'b1;
      hard_q[ev_idx] <= txop_hard;
`ifdef TXOP_AGING_EN
      age_q[ev_idx]  <= '0;
`endif
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign rd_occ         = rd_occ_q;
  assign rd_hard        = rd_hard_q;
  assign clear_done     = clear_done_q;
  assign sweep_done     = sweep_done_q;
  assign free_count     = free_count_q;
  assign hard_count     = hard_count_q;
  assign first_free     = first_free_q;
  assign free_valid     = free_valid_q;
  assign max_hard_claim = max_hard_q;
  assign sweep_overrun  = overrun_q;

endmodule

// File: tb/tb_plca_txop_table_writer.sv
// Bench for plca_txop_table_writer: directed and random TXOP activity
// checked against an array model of the occupancy table.
module tb_plca_txop_table_writer;

  localparam int DEPTH = 256;
  localparam int LIMIT = 8;
  localparam int AMAX  = 15;
  localparam int MAXH  = 4;

  logic       clk = 1'b0;
  logic       reset, clear_req, cycle_start;
  logic       txop_valid, txop_active, txop_hard;
  logic [7:0] txop_id, rd_id;
  logic       rd_occ, rd_hard, busy, clear_done, sweep_done;
  logic [8:0] free_count, hard_count;
  logic [7:0] first_free;
  logic       free_valid, max_hard_claim, sweep_overrun;

  plca_txop_table_writer dut (
    .clk(clk), .reset(reset), .clear_req(clear_req),
    .cycle_start(cycle_start), .txop_valid(txop_valid),
    .txop_id(txop_id), .txop_active(txop_active),
    .txop_hard(txop_hard), .rd_id(rd_id), .rd_occ(rd_occ),
    .rd_hard(rd_hard), .busy(busy), .clear_done(clear_done),
    .sweep_done(sweep_done), .free_count(free_count),
    .hard_count(hard_count), .first_free(first_free),
    .free_valid(free_valid), .max_hard_claim(max_hard_claim),
    .sweep_overrun(sweep_overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  bit m_occ  [DEPTH];
  bit m_hard [DEPTH];
  int m_age  [DEPTH];

  logic [27:0] act_sum;
  assign act_sum = {free_count, hard_count, first_free,
                    free_valid, max_hard_claim};

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_occ[i] = 0; m_hard[i] = 0; m_age[i] = 0;
    end
  endfunction

  function automatic void m_event(int id, bit act, bit hd);
    if (act && id < DEPTH) begin
      m_occ[id] = 1; m_hard[id] = hd; m_age[id] = 0;
    end
  endfunction

  function automatic void m_age_all();
`ifdef TXOP_AGING_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (m_occ[i]) begin
        m_age[i] = (m_age[i] >= AMAX) ? AMAX : m_age[i] + 1;
        if (m_age[i] == LIMIT) begin
          m_occ[i] = 0; m_hard[i] = 0;
        end
      end
    end
`endif
  endfunction

  function automatic logic [27:0] exp_sum();
    int f, h, ff;
    f = 0; h = 0; ff = 0;
    for (int i = 1; i < DEPTH; i++) begin
      if (!m_occ[i]) begin
        f++;
        if (ff == 0) ff = i;
      end
      if (m_hard[i]) h++;
    end
    return {9'(f), 9'(h), 8'(ff), (ff != 0), (h >= MAXH)};
  endfunction

  task automatic send_event(input int id, input bit act, input bit hd);
    @(negedge clk);
    txop_valid = 1; txop_id = 8'(id); txop_active = act; txop_hard = hd;
    @(negedge clk);
    txop_valid = 0; txop_active = 0; txop_hard = 0;
    m_event(id, act, hd);
  endtask

  task automatic run_sweep(output int n, output bit seen);
    @(negedge clk); cycle_start = 1;
    @(posedge clk); #1; cycle_start = 0;
    n = 1; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1; n++;
      seen = sweep_done;
    end
  endtask

  task automatic run_clear(output int n, output bit seen);
    @(negedge clk); clear_req = 1;
    @(posedge clk); #1; clear_req = 0;
    n = 1; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1; n++;
      seen = clear_done;
    end
  endtask

  task automatic do_read(input int id, output bit o, output bit h);
    @(negedge clk); rd_id = 8'(id);
    @(posedge clk); #1;
    o = rd_occ; h = rd_hard;
  endtask

  task automatic test_reset();
    int n; bit busy_bad;
    reset = 1; clear_req = 0; cycle_start = 0; txop_valid = 0;
    txop_id = 0; txop_active = 0; txop_hard = 0; rd_id = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({act_sum, clear_done, sweep_done, sweep_overrun, rd_occ, rd_hard}
        !== 33'd0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_state got sum=%h busy=%b exp sum=0 busy=1",
               act_sum, busy);
    end
    @(negedge clk); reset = 0;
    n = 0; busy_bad = 0;
    while (clear_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
      if (clear_done !== 1'b1 && busy !== 1'b1) busy_bad = 1;
    end
    m_clear();
    checks++;
    if (n != 256 || busy_bad) begin
      failures++;
      $display("FAIL reset_clear_len got=%0d busy_bad=%b exp=256", n, busy_bad);
    end
    checks++;
    if (busy !== 1'b0 || act_sum !== exp_sum()) begin
      failures++;
      $display("FAIL reset_clear_sum got=%h busy=%b exp=%h",
               act_sum, busy, exp_sum());
    end
    @(posedge clk); #1;
    checks++;
    if (clear_done !== 1'b0) begin
      failures++;
      $display("FAIL clear_done_pulse got=%b exp=0", clear_done);
    end
  endtask

  task automatic test_single_hard();
    int n; bit seen, o, h;
    send_event(5, 1, 1);
    run_sweep(n, seen);
    m_age_all();
    checks++;
    if (!seen || n != 257) begin
      failures++;
      $display("FAIL sweep_latency got=%0d seen=%b exp=257", n, seen);
    end
    checks++;
    if (act_sum !== exp_sum() || act_sum !== {9'd254, 9'd1, 8'd1, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL single_hard_sum got=%h exp=%h", act_sum, exp_sum());
    end
    do_read(5, o, h);
    checks++;
    if ({o, h} !== 2'b11) begin
      failures++;
      $display("FAIL read_id5 got=%b%b exp=11", o, h);
    end
    do_read(6, o, h);
    checks++;
    if ({o, h} !== 2'b00) begin
      failures++;
      $display("FAIL read_id6 got=%b%b exp=00", o, h);
    end
  endtask

  task automatic test_max_hard();
    int n; bit seen;
    for (int i = 1; i <= 4; i++) send_event(i, 1, 1);
    run_sweep(n, seen);
    m_age_all();
    checks++;
    if (!seen || act_sum !== exp_sum() || max_hard_claim !== 1'b1) begin
      failures++;
      $display("FAIL max_hard_sum got=%h seen=%b exp=%h",
               act_sum, seen, exp_sum());
    end
    run_clear(n, seen);
    m_clear();
    checks++;
    if (!seen || n != 257) begin
      failures++;
      $display("FAIL clear_req_len got=%0d seen=%b exp=257", n, seen);
    end
    checks++;
    if (act_sum !== exp_sum() || max_hard_claim !== 1'b0 ||
        first_free !== 8'd1) begin
      failures++;
      $display("FAIL after_clear_sum got=%h exp=%h", act_sum, exp_sum());
    end
  endtask

  task automatic test_aging();
    int n; bit seen, o, h;
    send_event(7, 1, 0);
    for (int s = 1; s <= 8; s++) begin
      run_sweep(n, seen);
      m_age_all();
      do_read(7, o, h);
      checks++;
      if (!seen || o !== m_occ[7] || act_sum !== exp_sum()) begin
        failures++;
        $display("FAIL aging_sweep%0d got occ=%b sum=%h exp occ=%b sum=%h",
                 s, o, act_sum, m_occ[7], exp_sum());
      end
    end
  endtask

  task automatic test_collision();
    int n; bit seen, o, h;
    run_clear(n, seen);
    m_clear();
    send_event(10, 1, 0);
    for (int s = 1; s <= 7; s++) begin
      run_sweep(n, seen);
      m_age_all();
    end
    @(negedge clk); cycle_start = 1;
    @(posedge clk); #1; cycle_start = 0;
    n = 1; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1; n++;
      seen = sweep_done;
      if (n == 11) begin
        txop_valid = 1; txop_id = 8'd10; txop_active = 1; txop_hard = 1;
      end else if (n == 12) begin
        txop_valid = 0; txop_active = 0; txop_hard = 0;
      end
    end
    m_age_all();
    m_event(10, 1, 1);
    checks++;
    if (!seen || n != 257 || act_sum !== exp_sum()) begin
      failures++;
      $display("FAIL collision_sum got=%h n=%0d exp=%h", act_sum, n, exp_sum());
    end
    do_read(10, o, h);
    checks++;
    if ({o, h} !== 2'b11) begin
      failures++;
      $display("FAIL collision_read got=%b%b exp=11", o, h);
    end
    run_sweep(n, seen);
    m_age_all();
    do_read(10, o, h);
    checks++;
    if (o !== m_occ[10] || act_sum !== exp_sum()) begin
      failures++;
      $display("FAIL collision_age0 got occ=%b sum=%h exp occ=%b sum=%h",
               o, act_sum, m_occ[10], exp_sum());
    end
  endtask

  task automatic test_random();
    int n, k, id; bit seen, o, h;
    for (int r = 0; r < 4; r++) begin
      k = $urandom_range(40, 5);
      for (int e = 0; e < k; e++)
        send_event($urandom_range(255, 1), 1'($urandom), 1'($urandom));
      run_sweep(n, seen);
      m_age_all();
      checks++;
      if (!seen || act_sum !== exp_sum()) begin
        failures++;
        $display("FAIL random_sum%0d got=%h exp=%h", r, act_sum, exp_sum());
      end
      for (int q = 0; q < 6; q++) begin
        id = $urandom_range(255, 0);
        do_read(id, o, h);
        checks++;
        if ({o, h} !== {m_occ[id], m_hard[id]}) begin
          failures++;
          $display("FAIL random_read id=%0d got=%b%b exp=%b%b",
                   id, o, h, m_occ[id], m_hard[id]);
        end
      end
    end
  endtask

  task automatic test_full();
    int n; bit seen;
    for (int i = 1; i < DEPTH; i++) send_event(i, 1, i[0]);
    run_sweep(n, seen);
    m_age_all();
    checks++;
    if (!seen || act_sum !== exp_sum() || free_valid !== 1'b0 ||
        first_free !== 8'd0) begin
      failures++;
      $display("FAIL full_table got=%h exp=%h", act_sum, exp_sum());
    end
  endtask

  task automatic test_overrun();
    int n; bit seen, sd_seen;
    checks++;
    if (sweep_overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_initial got=%b exp=0", sweep_overrun);
    end
    @(negedge clk); cycle_start = 1;
    @(posedge clk); #1; cycle_start = 0;
    n = 1; seen = 0;
    while (!seen && n < 400) begin
      @(posedge clk); #1; n++;
      seen = sweep_done;
      if (n == 20) cycle_start = 1;
      else if (n == 21) cycle_start = 0;
    end
    m_age_all();
    checks++;
    if (!seen || n != 257 || sweep_overrun !== 1'b1 ||
        act_sum !== exp_sum()) begin
      failures++;
      $display("FAIL overrun_sweep got n=%0d ovr=%b sum=%h exp n=257 ovr=1 sum=%h",
               n, sweep_overrun, act_sum, exp_sum());
    end
    @(negedge clk); cycle_start = 1;
    @(posedge clk); #1; cycle_start = 0;
    n = 1; seen = 0; sd_seen = 0;
    while (!seen && n < 500) begin
      @(posedge clk); #1; n++;
      seen = clear_done;
      if (sweep_done === 1'b1) sd_seen = 1;
      if (n == 50) clear_req = 1;
      else if (n == 51) clear_req = 0;
    end
    m_clear();
    checks++;
    if (!seen || sd_seen || n != 307) begin
      failures++;
      $display("FAIL abort_sweep got n=%0d sweep_done_seen=%b exp n=307 seen=0",
               n, sd_seen);
    end
    checks++;
    if (sweep_overrun !== 1'b1 || act_sum !== exp_sum()) begin
      failures++;
      $display("FAIL abort_state got ovr=%b sum=%h exp ovr=1 sum=%h",
               sweep_overrun, act_sum, exp_sum());
    end
  endtask

  initial begin
    test_reset();
    test_single_hard();
    test_max_hard();
    test_aging();
    test_collision();
    test_random();
    test_full();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
